// File: rtl/ar_arbiter.sv
// ar_arbiter: shares one AXI AR channel among NUM_SRC requesters.
// A round-robin arbiter feeds a single-entry registered output stage; the
// winning source index is prepended to the outgoing ID for R-channel routing.
// Optional macro AR_ARB_QOS_EN: highest s_qos wins, ties broken round-robin.
// Without it, arbitration is pure round-robin and s_qos is only passed through.
module ar_arbiter #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_SRC),
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned SIZE_WIDTH  = 3,
    parameter int unsigned BURST_WIDTH = 2,
    parameter int unsigned QOS_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              s_valid,
    input  logic [NUM_SRC*ID_WIDTH-1:0]     s_id,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]   s_addr,
    input  logic [NUM_SRC*LEN_WIDTH-1:0]    s_len,
    input  logic [NUM_SRC*SIZE_WIDTH-1:0]   s_size,
    input  logic [NUM_SRC*BURST_WIDTH-1:0]  s_burst,
    input  logic [NUM_SRC*QOS_WIDTH-1:0]    s_qos,
    output logic [NUM_SRC-1:0]              s_ready,
    output logic                            m_valid,
    output logic [IDX_WIDTH+ID_WIDTH-1:0]   m_id,
    output logic [ADDR_WIDTH-1:0]           m_addr,
    output logic [LEN_WIDTH-1:0]            m_len,
    output logic [SIZE_WIDTH-1:0]           m_size,
    output logic [BURST_WIDTH-1:0]          m_burst,
    output logic [QOS_WIDTH-1:0]            m_qos,
    input  logic                            m_ready,
    output logic [IDX_WIDTH-1:0]            grant_idx
);

    logic                           m_valid_q;
    logic [IDX_WIDTH+ID_WIDTH-1:0]  m_id_q;
    logic [ADDR_WIDTH-1:0]          m_addr_q;
    logic [LEN_WIDTH-1:0]           m_len_q;
    logic [SIZE_WIDTH-1:0]          m_size_q;
    logic [BURST_WIDTH-1:0]         m_burst_q;
    logic [QOS_WIDTH-1:0]           m_qos_q;
    logic [IDX_WIDTH-1:0]           grant_idx_q;
    logic [IDX_WIDTH-1:0]           ptr_q, ptr_d;

    logic                           load_ok;
    logic                           found;
    logic                           grant;
    logic [IDX_WIDTH-1:0]           win_idx;

    // Stage can take a new request when empty or when it is being drained now.
    assign load_ok = !m_valid_q || m_ready;
    assign grant   = !rst && load_ok && found;

    // Winner search: first eligible valid requester starting at the RR pointer.
    always_comb begin : arb
        int unsigned cand;
`ifdef AR_ARB_QOS_EN
        logic [QOS_WIDTH-1:0] max_qos;
        max_qos = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (s_valid[i] && (s_qos[i*QOS_WIDTH +: QOS_WIDTH] > max_qos)) begin
                max_qos = s_qos[i*QOS_WIDTH +: QOS_WIDTH];
            end
        end
`endif
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (int'(ptr_q) + k) % NUM_SRC;
`ifdef AR_ARB_QOS_EN
            if (!found && s_valid[cand] &&
                (s_qos[cand*QOS_WIDTH +: QOS_WIDTH] == max_qos)) begin
`else
            if (!found && s_valid[cand]) begin
`endif
                found   = 1'b1;
                win_idx = IDX_WIDTH'(cand);
            end
        end
    end

    // One-hot ready to the winner; never while reset or the stage is blocked.
    always_comb begin
        s_ready = '0;
        if (grant) begin
            s_ready[win_idx] = 1'b1;
        end
    end

    // Pointer moves to the slot after the winner, wrapping at NUM_SRC-1.
    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (win_idx == IDX_WIDTH'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Output stage: reload on grant (no bubble), drain on accept, clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_id_q      <= '0;
            m_addr_q    <= '0;
            m_len_q     <= '0;
            m_size_q    <= '0;
            m_burst_q   <= '0;
            m_qos_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                m_valid_q   <= 1'b1;
                m_id_q      <= {win_idx, s_id[win_idx*ID_WIDTH +: ID_WIDTH]};
                m_addr_q    <= s_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                m_len_q     <= s_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
                m_size_q    <= s_size[win_idx*SIZE_WIDTH +: SIZE_WIDTH];
                m_burst_q   <= s_burst[win_idx*BURST_WIDTH +: BURST_WIDTH];
                m_qos_q     <= s_qos[win_idx*QOS_WIDTH +: QOS_WIDTH];
                grant_idx_q <= win_idx;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_id      = m_id_q;
    assign m_addr    = m_addr_q;
    assign m_len     = m_len_q;
    assign m_size    = m_size_q;
    assign m_burst   = m_burst_q;
    assign m_qos     = m_qos_q;
    assign grant_idx = grant_idx_q;

endmodule
